rx_dll_checker: RTL and testbench

RX_DLL_CHECKER -- requirements
Module: rx_dll_checker

---
 rtl/rx_dll_checker.sv | 158 +++++++++++++++
 tb/tb_rx_dll_checker.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/rx_dll_checker.sv
// Receive-side DLL checker: verifies sequence number and XOR checksum of each packet and
// forwards committed TLPs from a store-and-forward buffer. Optional macro RX_DLL_ERR_CNT_EN adds err_cnt.
module rx_dll_checker #(
    parameter int unsigned BUF_DEPTH = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] rx_tlp_data,
    input  logic        rx_tlp_valid,
    output logic        rx_tlp_ready,
    output logic        ack,
    output logic        nack,
`ifdef RX_DLL_ERR_CNT_EN
    output logic [15:0] err_cnt,
`endif
    output logic [31:0] tlp_out,
    output logic        tlp_out_valid,
    input  logic        tlp_out_ready,
    output logic        tlp_out_last
);

    localparam int unsigned AW = $clog2(BUF_DEPTH);

    typedef enum logic [1:0] {HDR, PAY, CRC, DROP} state_t;

    state_t      state_q, state_d;
    logic [AW:0] spec_q, spec_d, cmt_q, cmt_d, rd_q, rd_d, occ_d;
    logic [11:0] exp_q, exp_d, seq_q, seq_d;
    logic [31:0] csum_q, csum_d;
    logic [10:0] cnt_q, cnt_d, len_p1;
    logic        ready_q, ready_d, ack_q, ack_d, nack_q, nack_d;
    logic        wr_en, wr_last, xfer, rd_en;
    logic [32:0] mem_q [BUF_DEPTH];

    assign len_p1        = {1'b0, rx_tlp_data[9:0]} + 11'd1;
    assign xfer          = rx_tlp_valid && ready_q;
    assign tlp_out_valid = (cmt_q != rd_q);
    assign rd_en         = tlp_out_valid && tlp_out_ready;
    // Read port is the memory itself; gating by valid keeps outputs at 0 during reset.
    assign tlp_out       = tlp_out_valid ? mem_q[rd_q[AW-1:0]][31:0] : '0;
    assign tlp_out_last  = tlp_out_valid && mem_q[rd_q[AW-1:0]][32];
    assign rx_tlp_ready  = ready_q;
    assign ack           = ack_q;
    assign nack          = nack_q;

    always_comb begin
        state_d = state_q;
        spec_d  = spec_q;
        cmt_d   = cmt_q;
        rd_d    = rd_q;
        exp_d   = exp_q;
        seq_d   = seq_q;
        csum_d  = csum_q;
        cnt_d   = cnt_q;
        ack_d   = 1'b0;
        nack_d  = 1'b0;
        wr_en   = 1'b0;
        wr_last = 1'b0;
        if (rd_en) rd_d = rd_q + 1'b1;
        if (xfer) begin
            unique case (state_q)
                HDR: begin
                    if ({21'b0, len_p1} > BUF_DEPTH) begin
                        state_d = DROP;
                        cnt_d   = len_p1;
                    end else begin
                        wr_en   = 1'b1;
                        wr_last = (rx_tlp_data[9:0] == '0);
                        spec_d  = spec_q + 1'b1;
                        seq_d   = rx_tlp_data[31:20];
                        csum_d  = rx_tlp_data;
                        cnt_d   = {1'b0, rx_tlp_data[9:0]};
                        state_d = wr_last ? CRC : PAY;
                    end
                end
                PAY: begin
                    wr_en   = 1'b1;
                    wr_last = (cnt_q == 11'd1);
                    spec_d  = spec_q + 1'b1;
                    csum_d  = csum_q ^ rx_tlp_data;
                    cnt_d   = cnt_q - 11'd1;
                    if (cnt_q == 11'd1) state_d = CRC;
                end
                CRC: begin
                    state_d = HDR;
                    if (rx_tlp_data == csum_q && seq_q == exp_q) begin
                        cmt_d = spec_q;
                        exp_d = exp_q + 12'd1;
                        ack_d = 1'b1;
                    end else begin
                        spec_d = cmt_q;
                        nack_d = 1'b1;
                    end
                end
                DROP: begin
                    cnt_d = cnt_q - 11'd1;
                    if (cnt_q == 11'd1) begin
                        state_d = HDR;
                        nack_d  = 1'b1;
                    end
                end
                default: state_d = HDR;
            endcase
        end
        // Occupancy never exceeds BUF_DEPTH, so the MSB alone flags a full buffer.
        occ_d   = spec_d - rd_d;
        ready_d = (state_d == CRC) || (state_d == DROP) || !occ_d[AW];
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= HDR;
            spec_q  <= '0;
            cmt_q   <= '0;
            rd_q    <= '0;
            exp_q   <= '0;
            seq_q   <= '0;
            csum_q  <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            ack_q   <= 1'b0;
            nack_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            spec_q  <= spec_d;
            cmt_q   <= cmt_d;
            rd_q    <= rd_d;
            exp_q   <= exp_d;
            seq_q   <= seq_d;
            csum_q  <= csum_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_d;
            ack_q   <= ack_d;
            nack_q  <= nack_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[spec_q[AW-1:0]] <= {wr_last, rx_tlp_data};
    end

`ifdef RX_DLL_ERR_CNT_EN
    logic [15:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (nack_d && err_cnt_q != '1) err_cnt_d = err_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) err_cnt_q <= '0;
        else          err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_rx_dll_checker.sv
// Directed bench for rx_dll_checker; inputs change and outputs are sampled on the falling edge.
module tb_rx_dll_checker;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] rx_tlp_data = '0;
    logic        rx_tlp_valid = 1'b0;
    logic        rx_tlp_ready;
    logic        ack, nack;
    logic [31:0] tlp_out;
    logic        tlp_out_valid;
    logic        tlp_out_ready = 1'b0;
    logic        tlp_out_last;
`ifdef RX_DLL_ERR_CNT_EN
    logic [15:0] err_cnt;
`endif

    int errors = 0;
    int checks = 0;
    int ack_cnt = 0;
    int nack_cnt = 0;
    int both_cnt = 0;

    rx_dll_checker #(.BUF_DEPTH(16)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .rx_tlp_data   (rx_tlp_data),
        .rx_tlp_valid  (rx_tlp_valid),
        .rx_tlp_ready  (rx_tlp_ready),
        .ack           (ack),
        .nack          (nack),
`ifdef RX_DLL_ERR_CNT_EN
        .err_cnt       (err_cnt),
`endif
        .tlp_out       (tlp_out),
        .tlp_out_valid (tlp_out_valid),
        .tlp_out_ready (tlp_out_ready),
        .tlp_out_last  (tlp_out_last)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ack) ack_cnt++;
        if (nack) nack_cnt++;
        if (ack && nack) both_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after the word transferred.
    task automatic send(input logic [31:0] d);
        int n = 0;
        rx_tlp_data  = d;
        rx_tlp_valid = 1'b1;
        while (!rx_tlp_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("tmo_send", {31'b0, rx_tlp_ready}, 32'd1);
        @(negedge clk);
    endtask

    task automatic send_pkt(input logic [11:0] seq, input logic [9:0] len,
                            input logic [31:0] base, input logic exp_ack);
        logic [31:0] hdr, cs;
        hdr = {seq, 10'b0, len};
        cs  = hdr;
        send(hdr);
        for (int i = 0; i < int'(len); i++) begin
            send(base + i);
            cs = cs ^ (base + i);
        end
        send(cs);
        rx_tlp_valid = 1'b0;
        check("pkt_ack", {31'b0, ack}, {31'b0, exp_ack});
        check("pkt_nack", {31'b0, nack}, {31'b0, !exp_ack});
    endtask

    task automatic recv(input logic [31:0] d, input logic l);
        int n = 0;
        while (!tlp_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check("tmo_recv", {31'b0, tlp_out_valid}, 32'd1);
        check("tlp_out", tlp_out, d);
        check("tlp_last", {31'b0, tlp_out_last}, {31'b0, l});
        tlp_out_ready = 1'b1;
        @(negedge clk);
        tlp_out_ready = 1'b0;
    endtask

    task automatic recv_pkt(input logic [11:0] seq, input logic [9:0] len, input logic [31:0] base);
        recv({seq, 10'b0, len}, len == 10'd0);
        for (int i = 0; i < int'(len); i++) recv(base + i, i == int'(len) - 1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ready"}, {31'b0, rx_tlp_ready}, 32'd0);
        check({tag, "_ack"},   {31'b0, ack}, 32'd0);
        check({tag, "_nack"},  {31'b0, nack}, 32'd0);
        check({tag, "_valid"}, {31'b0, tlp_out_valid}, 32'd0);
        check({tag, "_last"},  {31'b0, tlp_out_last}, 32'd0);
        check({tag, "_data"},  tlp_out, 32'd0);
    endtask

    initial begin
        int a0, n0;

        repeat (3) @(negedge clk);
        check_idle_outputs("rst");
        reset_n = 1'b1;
        #1 check("rdy_before_edge", {31'b0, rx_tlp_ready}, 32'd0);
        @(negedge clk);
        check("rdy_after_edge", {31'b0, rx_tlp_ready}, 32'd1);
`ifdef RX_DLL_ERR_CNT_EN
        check("err_cnt_rst", {16'b0, err_cnt}, 32'd0);
`endif

        // Bad checksum: rejected, nothing presented
        send(32'h0000_0002); send(32'hA5A5_A5A5); send(32'h1234_5678); send(32'hB791_F3DE);
        rx_tlp_valid = 1'b0;
        check("bad_cs_nack", {31'b0, nack}, 32'd1);
        check("bad_cs_ack", {31'b0, ack}, 32'd0);
        repeat (2) @(negedge clk);
        check("bad_cs_valid", {31'b0, tlp_out_valid}, 32'd0);
`ifdef RX_DLL_ERR_CNT_EN
        check("err_cnt_one", {16'b0, err_cnt}, 32'd1);
`endif

        // Good packet: ack and valid one cycle after checksum
        send(32'h0000_0002); send(32'hA5A5_A5A5); send(32'h1234_5678); send(32'hB791_F3DF);
        rx_tlp_valid = 1'b0;
        check("good_ack", {31'b0, ack}, 32'd1);
        check("good_nack", {31'b0, nack}, 32'd0);
        check("good_valid_lat", {31'b0, tlp_out_valid}, 32'd1);
        recv(32'h0000_0002, 1'b0);
        recv(32'hA5A5_A5A5, 1'b0);
        recv(32'h1234_5678, 1'b1);
        check("good_drained", {31'b0, tlp_out_valid}, 32'd0);

        // Wrong sequence number, then the expected one
        send_pkt(12'd5, 10'd2, 32'h5555_0000, 1'b0);
        repeat (2) @(negedge clk);
        check("seq_bad_valid", {31'b0, tlp_out_valid}, 32'd0);
        send_pkt(12'd1, 10'd3, 32'h1000_0000, 1'b1);
        recv_pkt(12'd1, 10'd3, 32'h1000_0000);

        // Oversized packet is drained with ready held high
        send(32'h0020_0014);
        for (int i = 0; i < 21; i++) begin
            check("drop_ready", {31'b0, rx_tlp_ready}, 32'd1);
            send(32'hD000_0000 + i);
        end
        rx_tlp_valid = 1'b0;
        check("drop_nack", {31'b0, nack}, 32'd1);
        check("drop_ack", {31'b0, ack}, 32'd0);
        check("drop_valid", {31'b0, tlp_out_valid}, 32'd0);
        send_pkt(12'd2, 10'd1, 32'h2000_0000, 1'b1);
        recv_pkt(12'd2, 10'd1, 32'h2000_0000);

        // Backpressure: two 8-word packets fill the 16-word buffer
        send_pkt(12'd3, 10'd7, 32'h3000_0000, 1'b1);
        send_pkt(12'd4, 10'd7, 32'h4000_0000, 1'b1);
        check("full_ready", {31'b0, rx_tlp_ready}, 32'd0);
        check("full_valid", {31'b0, tlp_out_valid}, 32'd1);
        repeat (3) @(negedge clk);
        check("hold_data", tlp_out, 32'h0030_0007);
        check("hold_ready", {31'b0, rx_tlp_ready}, 32'd0);
        recv_pkt(12'd3, 10'd7, 32'h3000_0000);
        recv_pkt(12'd4, 10'd7, 32'h4000_0000);
        check("drain_ready", {31'b0, rx_tlp_ready}, 32'd1);
        check("drain_valid", {31'b0, tlp_out_valid}, 32'd0);

        // Reset after three payload words
        send(32'h0050_0004); send(32'h5000_0000); send(32'h5000_0001); send(32'h5000_0002);
        rx_tlp_valid = 1'b0;
        a0 = ack_cnt;
        n0 = nack_cnt;
        reset_n = 1'b0;
        #1 check_idle_outputs("mid_rst");
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_rst_acks", ack_cnt - a0, 32'd0);
        check("mid_rst_nacks", nack_cnt - n0, 32'd0);
        check("mid_rst_valid", {31'b0, tlp_out_valid}, 32'd0);
`ifdef RX_DLL_ERR_CNT_EN
        check("err_cnt_mid_rst", {16'b0, err_cnt}, 32'd0);
`endif
        send_pkt(12'd0, 10'd0, 32'h0, 1'b1);
        recv(32'h0000_0000, 1'b1);
        repeat (2) @(negedge clk);

        check("total_acks", ack_cnt, 32'd6);
        check("total_nacks", nack_cnt, 32'd3);
        check("ack_nack_excl", both_cnt, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
